// File: rtl/second_tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : second_tick_timer
// Description : Turns the toggling one-second clock level into single-cycle
//               ticks in the clk domain and runs a loadable seconds countdown
//               on them, pulsing timeout once when the count expires.
//
// Ports       : clk           system clock
//               reset         synchronous, active-high reset
//               clk_1_second  divided clock level, one rising edge per second
//               start         one-cycle request to load load_value and count
//               cancel        one-cycle request to abort the countdown
//               load_value    timeout in seconds (sampled with start)
//               pause         hold the countdown while high (optional)
//               tick          one-cycle pulse per clk_1_second rising edge
//               busy          high while counting
//               remaining     seconds left
//               timeout       one-cycle pulse on expiry
//
// Options     : define SECOND_TICK_TIMER_PAUSE_EN to add the pause input.
//
// Revision    : 1.0 - initial release
// ============================================================================
module second_tick_timer #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_1_second,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] load_value,
`ifdef SECOND_TICK_TIMER_PAUSE_EN
    input  logic             pause,
`endif
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] remaining,
    output logic             timeout
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_valid;
    logic                   r_prev;
    logic                   r_armed;
    logic                   r_tick;
    logic                   w_s_last;
    logic                   w_s_last_valid;

    assign w_s_last       = r_sync[SYNC_STAGES-1];
    // r_valid tracks which sync stages hold a real post-reset sample, so the
    // cleared chain contents are never mistaken for an observed low level.
    // Without this, a line already high at reset release would tick.
    assign w_s_last_valid = r_valid[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '0;
            r_valid <= '0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], clk_1_second};
            r_valid <= {r_valid[SYNC_STAGES-2:0], 1'b1};
            r_prev  <= w_s_last;
            if (w_s_last_valid && !w_s_last) begin
                r_armed <= 1'b1;
            end
            r_tick  <= r_armed & w_s_last & ~r_prev;
        end
    end

    assign tick = r_tick;

    // ------------------------------------------------------------------
    // Countdown FSM
    // ------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [WIDTH-1:0] r_remaining;
    logic [WIDTH-1:0] w_remaining_next;
    logic             r_timeout;
    logic             w_timeout_next;
    logic             w_tick_en;

`ifdef SECOND_TICK_TIMER_PAUSE_EN
    assign w_tick_en = r_tick & ~pause;
`else
    assign w_tick_en = r_tick;
`endif

    // State register (remaining and timeout are registered alongside it)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_remaining <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_timeout   <= w_timeout_next;
        end
    end

    // Next-state logic; priority cancel > start > tick
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_timeout_next   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!cancel && start) begin
                    if (load_value == '0) begin
                        w_timeout_next = 1'b1;
                    end else begin
                        w_state_next     = c_ST_RUN;
                        w_remaining_next = load_value;
                    end
                end
            end
            c_ST_RUN: begin
                if (cancel) begin
                    w_state_next     = c_ST_IDLE;
                    w_remaining_next = '0;
                end else if (start) begin
                    // Reload wins over a coincident tick; a zero load expires.
                    if (load_value == '0) begin
                        w_state_next     = c_ST_IDLE;
                        w_remaining_next = '0;
                        w_timeout_next   = 1'b1;
                    end else begin
                        w_remaining_next = load_value;
                    end
                end else if (w_tick_en) begin
                    if (r_remaining > WIDTH'(1)) begin
                        w_remaining_next = r_remaining - WIDTH'(1);
                    end else begin
                        w_state_next     = c_ST_IDLE;
                        w_remaining_next = '0;
                        w_timeout_next   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next     = c_ST_IDLE;
                w_remaining_next = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (r_state == c_ST_RUN);
        remaining = r_remaining;
        timeout   = r_timeout;
    end

endmodule
`default_nettype wire

// File: tb/tb_second_tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_second_tick_timer
// Description : Self-checking bench for second_tick_timer. A behavioural
//               model derives tick from the history of sampled clk_1_second
//               levels and tracks the countdown from the input rules; every
//               output is compared each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_second_tick_timer;

    localparam int W  = 8;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         clk_1_second;
    logic         start;
    logic         cancel;
    logic [W-1:0] load_value;
    logic         pause;
    logic         tick;
    logic         busy;
    logic [W-1:0] remaining;
    logic         timeout;

    always #5 clk = ~clk;

    second_tick_timer #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_1_second (clk_1_second),
        .start        (start),
        .cancel       (cancel),
        .load_value   (load_value),
`ifdef SECOND_TICK_TIMER_PAUSE_EN
        .pause        (pause),
`endif
        .tick         (tick),
        .busy         (busy),
        .remaining    (remaining),
        .timeout      (timeout)
    );

    int checks   = 0;
    int failures = 0;

    // Model state
    bit           hist[$];   // clk_1_second samples since reset release
    bit           m_tick;
    bit           m_busy;
    bit           m_to;
    logic [W-1:0] m_rem;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: advance the model on the edge, then compare all outputs.
    task automatic cycle();
        int e;
        bit nt;
        bit tick_in;
        @(posedge clk);
        if (reset) begin
            hist.delete();
            m_tick = 0; m_busy = 0; m_rem = '0; m_to = 0;
        end else begin
            hist.push_back(clk_1_second);
            e  = hist.size();
            // Rising edge between two post-reset samples, seen SS+1 edges later.
            nt = (e >= SS + 2) && hist[e-SS-1] && !hist[e-SS-2];
            tick_in = m_tick;
`ifdef SECOND_TICK_TIMER_PAUSE_EN
            if (pause) tick_in = 0;
`endif
            m_to = 0;
            if (m_busy) begin
                if (cancel) begin
                    m_busy = 0; m_rem = '0;
                end else if (start) begin
                    if (load_value == 0) begin
                        m_busy = 0; m_rem = '0; m_to = 1;
                    end else begin
                        m_rem = load_value;
                    end
                end else if (tick_in) begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
                        m_busy = 0; m_to = 1;
                    end
                end
            end else if (!cancel && start) begin
                if (load_value == 0) m_to = 1;
                else begin
                    m_busy = 1; m_rem = load_value;
                end
            end
            m_tick = nt;
        end
        #1;
        check("tick",      32'(tick),      32'(m_tick));
        check("busy",      32'(busy),      32'(m_busy));
        check("remaining", 32'(remaining), 32'(m_rem));
        check("timeout",   32'(timeout),   32'(m_to));
    endtask

    task automatic run(input int n, input logic lvl);
        clk_1_second = lvl;
        repeat (n) cycle();
    endtask

    task automatic pulse_start(input logic [W-1:0] lv);
        start = 1'b1; load_value = lv;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        int tc;
        int hold;
        reset = 1'b1; clk_1_second = 1'b1; start = 1'b0; cancel = 1'b0;
        load_value = '0; pause = 1'b0;
        repeat (3) cycle();
        reset = 1'b0;

        // Line high at release, then low, then high: exactly one tick.
        tc = 0;
        clk_1_second = 1'b1;
        for (int i = 0; i < 20; i++) begin
            clk_1_second = (i >= 8 && i < 12) ? 1'b0 : 1'b1;
            cycle();
            if (tick) tc++;
        end
        check("tick_count", tc, 1);
        run(4, 1'b0);

        // Load 3, four edges: a single timeout.
        tc = 0;
        pulse_start(8'd3);
        repeat (4) begin
            for (int i = 0; i < 8; i++) begin
                clk_1_second = (i < 4);
                cycle();
                if (timeout) tc++;
            end
        end
        check("timeout_count", tc, 1);

        // Load 5, cancel after two ticks.
        pulse_start(8'd5);
        repeat (2) begin run(4, 1'b1); run(4, 1'b0); end
        cancel = 1'b1; cycle(); cancel = 1'b0;
        run(4, 1'b1); run(4, 1'b0);

        // Zero load from IDLE.
        pulse_start(8'd0);
        run(3, 1'b0);

        // Reload coincident with the final tick, then reset mid-run.
        pulse_start(8'd2);
        run(4, 1'b1); run(4, 1'b0);
        clk_1_second = 1'b1;
        for (int i = 0; i < 10 && !m_tick; i++) cycle();
        check("tick_seen", 32'(m_tick), 32'd1);
        start = 1'b1; load_value = 8'd4; cycle(); start = 1'b0;
        check("reload_rem", 32'(remaining), 32'd4);
        run(3, 1'b1);
        repeat (2) begin run(4, 1'b0); run(4, 1'b1); end
        run(2, 1'b0);
        reset = 1'b1; cycle(); reset = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        run(6, 1'b0);

`ifdef SECOND_TICK_TIMER_PAUSE_EN
        // Pause across two ticks, then three unpaused ticks.
        pulse_start(8'd3);
        pause = 1'b1;
        repeat (2) begin run(4, 1'b1); run(4, 1'b0); end
        check("pause_hold", 32'(remaining), 32'd3);
        pause = 1'b0;
        repeat (3) begin run(4, 1'b1); run(4, 1'b0); end
`endif

        // Randomised traffic.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                clk_1_second = ~clk_1_second;
                hold = $urandom_range(2, 7);
            end
            hold--;
            start  = ($urandom_range(0, 39) == 0);
            cancel = ($urandom_range(0, 79) == 0);
            reset  = ($urandom_range(0, 499) == 0);
            pause  = ($urandom_range(0, 3) == 0);
            load_value = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
